fx3_stream_packer: RTL

Parametrised FX3 output stage in the `fx3_clock` domain. It packs ADC samples (or test-mode counter values) into 16- or 32-bit GPIF bus words and buffers them in an internal FIFO. It flags `dataAvailable` once a full FX3 burst is buffered and pops one word per cycle while the FX3 reads. It replaces the fixed 16-bit, one-sample-per-word output path with configurable bus width, FIFO depth and burst threshold, a fill-level output, and sticky overflow/underflow reporting.

---
 rtl/fx3_stream_packer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fx3_stream_packer.sv
// -----------------------------------------------------------------------------
// fx3_stream_packer
//
// FX3 GPIF output stage in the fx3_clock domain. Packs ADC samples (or a
// free-running test counter) into 16- or 32-bit bus words, buffers them in a
// circular FIFO, raises dataAvailable once a full burst is buffered, and pops
// one word per cycle while the FX3 reads.
//
// Parameters:
//   SAMPLE_WIDTH  ADC sample width (1..16)
//   BUS_WIDTH     FX3 data bus width (16 or 32); LANES = BUS_WIDTH/16
//   FIFO_DEPTH    FIFO depth in bus words (power of two, >= 4)
//   BURST_WORDS   fill threshold for dataAvailable (1..FIFO_DEPTH)
//
// Ports:
//   fx3_clock      only clock, rising edge
//   reset          asynchronous, active-high
//   collectData    1 = accept samples, 0 = discard samples and partial word
//   testMode       1 = pack the test counter instead of sampleData
//   sampleValid    sampleData is valid this cycle
//   sampleData     unsigned ADC sample
//   readData       FX3 is sampling the bus; pop one word this cycle
//   dataOut        registered FIFO read data
//   dataAvailable  registered; high when fill >= BURST_WORDS
//   bufferError    sticky overflow/underflow flag
//   fillLevel      current FIFO word count
// -----------------------------------------------------------------------------
module fx3_stream_packer #(
  parameter int SAMPLE_WIDTH = 10,
  parameter int BUS_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 16384,
  parameter int BURST_WORDS  = 8192
) (
  input  logic                          fx3_clock,
  input  logic                          reset,
  input  logic                          collectData,
  input  logic                          testMode,
  input  logic                          sampleValid,
  input  logic [SAMPLE_WIDTH-1:0]       sampleData,
  input  logic                          readData,
  output logic [BUS_WIDTH-1:0]          dataOut,
  output logic                          dataAvailable,
  output logic                          bufferError,
  output logic [$clog2(FIFO_DEPTH):0]   fillLevel
);

  localparam int LANES = BUS_WIDTH / 16;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_FILL     = 1'b1;
  localparam logic [0:0]  LAST_LANE   = 1'(LANES - 1);
  localparam logic [AW:0] FULL_LEVEL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] BURST_LEVEL = (AW + 1)'(BURST_WORDS);

  // ---------------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------------
  logic [0:0]              state;
  logic [0:0]              lane_idx;
  logic [BUS_WIDTH-1:0]    partial_word;
  logic [SAMPLE_WIDTH-1:0] test_count;
  logic [BUS_WIDTH-1:0]    push_word;
  logic                    push_pending;

  logic                    accept;
  logic [15:0]             lane_value;
  logic [BUS_WIDTH-1:0]    word_next;

  assign accept     = (state == ST_FILL) && sampleValid;
  // Unsigned cast zero-extends the sample into its 16-bit lane.
  assign lane_value = 16'(testMode ? test_count : sampleData);

  // NOTE: word_next is assigned a default before the loop so every path
  // drives it and no latch is inferred.
  always_comb begin
    word_next = partial_word;
    for (int l = 0; l < LANES; l++) begin
      if (lane_idx == 1'(l)) word_next[16*l +: 16] = lane_value;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge fx3_clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      lane_idx     <= '0;
      partial_word <= '0;
      test_count   <= '0;
      push_word    <= '0;
      push_pending <= 1'b0;
    end else begin
      push_pending <= 1'b0;

      if (accept) begin
        test_count <= test_count + 1'b1;
        if (lane_idx == LAST_LANE) begin
          // Last lane completes the word; it is written to the FIFO next edge.
          push_word    <= word_next;
          push_pending <= 1'b1;
          lane_idx     <= '0;
        end else begin
          partial_word <= word_next;
          lane_idx     <= lane_idx + 1'b1;
        end
      end

      case (state)
        ST_IDLE: if (collectData) state <= ST_FILL;
        ST_FILL: begin
          if (!collectData) begin
            // Leaving FILL discards any partially packed word.
            state        <= ST_IDLE;
            lane_idx     <= '0;
            partial_word <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          fill;

  logic pop_ok;
  logic push_ok;
  logic underflow;
  logic overflow;

  // Both decisions use the fill before this cycle's push, so a push into an
  // empty FIFO alongside readData still lands and still counts as underflow,
  // and a push into a full FIFO alongside a pop is legal.
  assign pop_ok    = readData && (fill != '0);
  assign push_ok   = push_pending && ((fill != FULL_LEVEL) || pop_ok);
  assign underflow = readData && (fill == '0);
  assign overflow  = push_pending && (fill == FULL_LEVEL) && !pop_ok;

  // NOTE: the RAM array has no reset so it maps onto block RAM; its contents
  // are meaningless until written and are never read before then.
  always_ff @(posedge fx3_clock) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge fx3_clock or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      dataOut       <= '0;
      dataAvailable <= 1'b0;
      bufferError   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;

      if (pop_ok) begin
        dataOut <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end

      case ({push_ok, pop_ok})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase

      // Registered from the current count, so it trails fillLevel by a cycle.
      dataAvailable <= (fill >= BURST_LEVEL);

      if (underflow || overflow) bufferError <= 1'b1;
    end
  end

  assign fillLevel = fill;

endmodule
